// File: rtl/sift_ctrl_pkg.sv
// Shared types, widths and band classifier for the SIFT keypoint control path.
package sift_ctrl_pkg;

    localparam int unsigned KP_CNT_W = 11;
    localparam int unsigned THR_W    = 10;

    typedef enum logic [1:0] {StIdle, StCount, StEval, StUpdate} ctrl_state_e;

    typedef enum logic [1:0] {
        HIGH_THROUGHPUT = 2'd0,
        HIGH_ACCURACY   = 2'd1
    } adaptive_mode_e;

    typedef enum logic [1:0] {BandIn, BandLow, BandHigh} band_e;

    function automatic band_e classify(input logic [KP_CNT_W-1:0] cnt,
                                       input logic [KP_CNT_W-1:0] lo,
                                       input logic [KP_CNT_W-1:0] hi);
        band_e res;
        res = BandIn;
        if (cnt < lo) begin
            res = BandLow;
        end else if (cnt > hi) begin
            res = BandHigh;
        end
        return res;
    endfunction

endpackage

// File: rtl/kp_frame_counter.sv
// Saturating per-frame keypoint counter; restart reloads with the same-cycle keypoint.
module kp_frame_counter
    import sift_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                restart,
    input  logic                inc,
    output logic [KP_CNT_W-1:0] count
);

    logic [KP_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (restart) begin
            count_d = {{(KP_CNT_W-1){1'b0}}, inc};
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/keypoint_threshold_ctrl.sv
// Frame-level scheduler that nudges the keypoint filter threshold toward the mode's
// target band, one step per HYST consecutive out-of-band frames, committed at frame end.
module keypoint_threshold_ctrl
    import sift_ctrl_pkg::*;
#(
    parameter int          THR_INIT = 2,
    parameter int          THR_MIN  = -8,
    parameter int          THR_MAX  = 64,
    parameter int unsigned HYST     = 2,
    parameter int unsigned HT_LO    = 500,
    parameter int unsigned HT_HI    = 1000,
    parameter int unsigned HA_LO    = 1500,
    parameter int unsigned HA_HI    = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    adaptive_en,
    input  logic [1:0]              adaptive_mode,
    input  logic                    frame_start,
    input  logic                    frame_end,
    input  logic                    kp_valid,
    output logic signed [THR_W-1:0] filter_threshold,
    output logic                    thr_valid,
    output logic [KP_CNT_W-1:0]     kp_count_last,
    output logic                    busy
);

    localparam int unsigned STREAK_W = $clog2(HYST + 1);
    localparam int unsigned EXT_W    = THR_W + 1;
    localparam logic [STREAK_W-1:0]     HYST_S     = STREAK_W'(HYST);
    localparam logic signed [THR_W-1:0] THR_INIT_T = THR_W'(THR_INIT);
    localparam logic signed [EXT_W-1:0] THR_MIN_X  = EXT_W'(THR_MIN);
    localparam logic signed [EXT_W-1:0] THR_MAX_X  = EXT_W'(THR_MAX);

    ctrl_state_e             state_q, state_d;
    logic                    start_pend_q, start_pend_d;
    logic [KP_CNT_W-1:0]     kp_cnt;
    logic                    cnt_clr, cnt_restart, cnt_inc;
    logic [KP_CNT_W-1:0]     band_lo, band_hi;
    band_e                   band;
    logic [STREAK_W-1:0]     streak_q, streak_d;
    logic                    dir_q, dir_d;  // 1: last out-of-band frame was high
    logic signed [THR_W-1:0] thr_q, thr_d;
    logic                    thr_valid_q, thr_valid_d;
    logic [KP_CNT_W-1:0]     last_q, last_d;
    logic signed [EXT_W-1:0] thr_ext, thr_step, thr_clamped;

    kp_frame_counter u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .restart (cnt_restart),
        .inc     (cnt_inc),
        .count   (kp_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StCount;
            StCount:  if (frame_end) state_d = StEval;
            StEval:   state_d = StUpdate;
            StUpdate: state_d = (start_pend_q || frame_start) ? StCount : StIdle;
            default:  state_d = StIdle;
        endcase

        start_pend_d = start_pend_q;
        if (frame_start && ((state_q == StEval) || (state_q == StUpdate) ||
                            ((state_q == StCount) && frame_end))) begin
            start_pend_d = 1'b1;
        end
        if ((state_d == StCount) && (state_q != StCount)) begin
            start_pend_d = 1'b0;
        end
    end

    always_comb begin
        busy        = (state_q != StIdle);
        cnt_clr     = (state_q == StIdle) || (state_q == StUpdate);
        cnt_restart = (state_q == StCount) && frame_start && !frame_end;
        cnt_inc     = (state_q == StCount) && kp_valid;
    end

    // Reserved modes keep the full range in-band, so they never drive a step.
    always_comb begin
        band_lo = '0;
        band_hi = '1;
        case (adaptive_mode)
            HIGH_THROUGHPUT: begin
                band_lo = KP_CNT_W'(HT_LO);
                band_hi = KP_CNT_W'(HT_HI);
            end
            HIGH_ACCURACY: begin
                band_lo = KP_CNT_W'(HA_LO);
                band_hi = KP_CNT_W'(HA_HI);
            end
            default: ;
        endcase
        band = classify(kp_cnt, band_lo, band_hi);
    end

    always_comb begin
        thr_ext  = {thr_q[THR_W-1], thr_q};
        thr_step = dir_q ? (thr_ext + EXT_W'(1)) : (thr_ext - EXT_W'(1));
        if (thr_step < THR_MIN_X) begin
            thr_clamped = THR_MIN_X;
        end else if (thr_step > THR_MAX_X) begin
            thr_clamped = THR_MAX_X;
        end else begin
            thr_clamped = thr_step;
        end

        streak_d    = streak_q;
        dir_d       = dir_q;
        thr_d       = thr_q;
        last_d      = last_q;
        thr_valid_d = 1'b0;

        if (state_q == StEval) begin
            last_d = kp_cnt;
            if (band == BandIn) begin
                streak_d = '0;
            end else if ((band == BandHigh) == dir_q) begin
                if (streak_q != HYST_S) streak_d = streak_q + STREAK_W'(1);
            end else begin
                dir_d    = (band == BandHigh);
                streak_d = STREAK_W'(1);
            end
        end

        if (state_q == StUpdate) begin
            thr_valid_d = 1'b1;
            if (streak_q == HYST_S) begin
                thr_d    = thr_clamped[THR_W-1:0];
                streak_d = '0;
            end
        end

        if (!adaptive_en) begin
            thr_d       = THR_INIT_T;
            streak_d    = '0;
            thr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q    <= '0;
            dir_q       <= 1'b0;
            thr_q       <= THR_INIT_T;
            thr_valid_q <= 1'b0;
            last_q      <= '0;
        end else begin
            streak_q    <= streak_d;
            dir_q       <= dir_d;
            thr_q       <= thr_d;
            thr_valid_q <= thr_valid_d;
            last_q      <= last_d;
        end
    end

    assign filter_threshold = thr_q;
    assign thr_valid        = thr_valid_q;
    assign kp_count_last    = last_q;

endmodule

// File: tb/tb_keypoint_threshold_ctrl.sv
// Directed and randomized frames against a frame-level reference of the threshold scheduler.
module tb_keypoint_threshold_ctrl;

    localparam int THR_INIT = 2;
    localparam int THR_MIN  = -8;
    localparam int THR_MAX  = 3;
    localparam int HYST     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              adaptive_en;
    logic [1:0]        adaptive_mode;
    logic              frame_start;
    logic              frame_end;
    logic              kp_valid;
    logic signed [9:0] filter_threshold;
    logic              thr_valid;
    logic [10:0]       kp_count_last;
    logic              busy;

    int n_vec = 0;
    int n_bad = 0;
    int m_thr, m_streak, m_dir;

    always #5 clk = ~clk;

    keypoint_threshold_ctrl #(
        .THR_INIT (THR_INIT),
        .THR_MIN  (THR_MIN),
        .THR_MAX  (THR_MAX),
        .HYST     (HYST)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .adaptive_en      (adaptive_en),
        .adaptive_mode    (adaptive_mode),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .kp_valid         (kp_valid),
        .filter_threshold (filter_threshold),
        .thr_valid        (thr_valid),
        .kp_count_last    (kp_count_last),
        .busy             (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input integer obs, input integer exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_thr    = THR_INIT;
        m_streak = 0;
        m_dir    = 0;
    endfunction

    // One completed frame: returns the reported count, advances threshold state.
    function automatic int model_frame(input int n, input int mode, input bit en);
        int cnt  = (n > 2047) ? 2047 : n;
        int band = 0;
        if (mode == 0) begin
            if (cnt < 500) band = -1;
            else if (cnt > 1000) band = 1;
        end else if (mode == 1) begin
            if (cnt < 1500) band = -1;
            else if (cnt > 2000) band = 1;
        end
        if (!en) begin
            m_thr    = THR_INIT;
            m_streak = 0;
            return cnt;
        end
        if (band == 0) begin
            m_streak = 0;
        end else if (band == m_dir) begin
            m_streak = (m_streak < HYST) ? m_streak + 1 : HYST;
        end else begin
            m_dir    = band;
            m_streak = 1;
        end
        if (m_streak == HYST) begin
            m_thr = m_thr + m_dir;
            if (m_thr > THR_MAX) m_thr = THR_MAX;
            if (m_thr < THR_MIN) m_thr = THR_MIN;
            m_streak = 0;
        end
        return cnt;
    endfunction

    task automatic reset_dut();
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        kp_valid    = 1'b0;
        repeat (2) tick();
        check("rst_thr", filter_threshold, THR_INIT);
        check("rst_valid", thr_valid, 0);
        check("rst_last", kp_count_last, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // From IDLE; a keypoint on the start cycle must not be counted.
    task automatic begin_frame();
        frame_start = 1'b1;
        kp_valid    = 1'b1;
        tick();
        frame_start = 1'b0;
        kp_valid    = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid_low", thr_valid, 0);
    endtask

    task automatic send_kp(input int n);
        kp_valid = 1'b1;
        repeat (n) tick();
        kp_valid = 1'b0;
    endtask

    // In COUNT: n keypoints, the last on the frame_end cycle; pre were counted earlier.
    task automatic end_frame(input int n, input bit chain, input int pre);
        int exp_cnt;
        if (n > 0) send_kp(n - 1);
        kp_valid    = (n > 0);
        frame_end   = 1'b1;
        frame_start = chain;
        tick();
        frame_end   = 1'b0;
        frame_start = 1'b0;
        kp_valid    = 1'b1;
        exp_cnt = model_frame(n + pre, int'(adaptive_mode), adaptive_en);
        check("eval_busy", busy, 1);
        tick();
        check("kp_count_last", kp_count_last, exp_cnt);
        check("update_busy", busy, 1);
        tick();
        kp_valid = 1'b0;
        check("threshold", filter_threshold, m_thr);
        check("thr_valid", thr_valid, adaptive_en);
        check("after_update_busy", busy, chain);
    endtask

    initial begin
        bit chain;
        adaptive_en   = 1'b1;
        adaptive_mode = 2'd0;
        reset_dut();

        // HT, 300 per frame: low streak, one step on the second frame
        for (int i = 0; i < 3; i++) begin
            begin_frame();
            end_frame(300, 1'b0, 0);
        end

        // HA, saturating count; climbs to the upper clamp and keeps pulsing
        adaptive_mode = 2'd1;
        for (int i = 0; i < 6; i++) begin
            begin_frame();
            end_frame(2052, 1'b0, 0);
        end

        // Alternating directions never build a streak
        reset_dut();
        adaptive_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            begin_frame();
            end_frame((i % 2 == 0) ? 400 : 1200, 1'b0, 0);
        end

        // Restart mid-frame after 200; the restart-cycle keypoint counts
        begin_frame();
        send_kp(200);
        frame_start = 1'b1;
        kp_valid    = 1'b1;
        tick();
        frame_start = 1'b0;
        kp_valid    = 1'b0;
        end_frame(349, 1'b0, 1);

        // Back-to-back: end and start together, straight into the next COUNT
        begin_frame();
        end_frame(600, 1'b1, 0);
        end_frame(300, 1'b0, 0);

        // Walk the threshold to -1, then drop adaptive_en
        for (int i = 0; i < 40 && m_thr != -1; i++) begin
            begin_frame();
            end_frame((m_thr > -1) ? 0 : 1100, 1'b0, 0);
        end
        tick();
        check("pre_disable_thr", filter_threshold, -1);
        adaptive_en = 1'b0;
        tick();
        check("disable_thr", filter_threshold, THR_INIT);
        check("disable_valid", thr_valid, 0);
        m_thr    = THR_INIT;
        m_streak = 0;
        begin_frame();
        end_frame(1200, 1'b0, 0);
        adaptive_en = 1'b1;

        // Reset during COUNT discards the partial frame
        begin_frame();
        send_kp(100);
        reset_dut();
        begin_frame();
        end_frame(300, 1'b0, 0);

        // Randomized frames: count buckets, modes (incl. reserved), enables, chaining
        chain = 1'b0;
        for (int i = 0; i < 20; i++) begin
            int n;
            bit nxt;
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(0, 600);
                1:       n = $urandom_range(400, 1100);
                2:       n = $urandom_range(1400, 2100);
                default: n = $urandom_range(2040, 2060);
            endcase
            nxt = 1'($urandom_range(0, 1));
            if (!chain) begin
                adaptive_en   = ($urandom_range(0, 4) != 0);
                adaptive_mode = 2'($urandom_range(0, 3));
                repeat ($urandom_range(0, 3)) tick();
                begin_frame();
            end
            adaptive_mode = 2'($urandom_range(0, 3));
            end_frame(n, nxt, 0);
            chain = nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
